// File: rtl/inter_packet_delay_pkg.sv
// Shared OSNT generator definitions: inter-packet-delay FSM encodings and the
// position of the per-packet delay field inside the AXIS tuser sideband.
package inter_packet_delay_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ipd_state_e;

    localparam int TUSER_DELAY_LO = 32;
    localparam int TUSER_DELAY_HI = 63;

    localparam logic [31:0] GAP_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/inter_packet_delay.sv
// Enforces a minimum idle gap (in clock cycles) between AXIS packets by gating
// the first beat of each packet. Optional statistics: INTER_PACKET_DELAY_STATS_EN.
module inter_packet_delay
    import inter_packet_delay_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXI_DATA_WIDTH   = 32
) (
    input  logic                                 axi_aclk,
    input  logic                                 axi_aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic [(C_S_AXIS_DATA_WIDTH/8)-1:0]   s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
    input  logic                                 s_axis_tvalid,
    input  logic                                 s_axis_tlast,
    output logic                                 s_axis_tready,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [(C_M_AXIS_DATA_WIDTH/8)-1:0]   m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
    output logic                                 m_axis_tvalid,
    output logic                                 m_axis_tlast,
    input  logic                                 m_axis_tready,
    input  logic                                 sw_rst,
    input  logic                                 ipd_en,
    input  logic                                 use_reg_delay,
`ifdef INTER_PACKET_DELAY_STATS_EN
    output logic [31:0]                          pkt_cnt,
    output logic [31:0]                          stall_cnt,
`endif
    input  logic [C_S_AXI_DATA_WIDTH-1:0]        delay_reg
);

    ipd_state_e  state_q, state_d;
    logic [31:0] gap_q, gap_d;
    logic [31:0] delay;
    logic        pass;
    logic        hs;
    logic        last_hs;

    assign delay = use_reg_delay ? delay_reg[31:0]
                                 : s_axis_tuser[TUSER_DELAY_HI:TUSER_DELAY_LO];

    // Held closed during reset unless enforcement is disabled entirely.
    assign pass = ~ipd_en |
                  (axi_aresetn & ((state_q == ST_SEND) | (gap_q >= delay)));

    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tstrb  = s_axis_tstrb;
    assign m_axis_tuser  = s_axis_tuser;
    assign m_axis_tlast  = s_axis_tlast;
    assign m_axis_tvalid = s_axis_tvalid & pass;
    assign s_axis_tready = m_axis_tready & pass;

    assign hs      = s_axis_tvalid & s_axis_tready;
    assign last_hs = hs & s_axis_tlast;

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        if (sw_rst) begin
            state_d = ST_IDLE;
            gap_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hs && !s_axis_tlast) state_d = ST_SEND;
                    if (gap_q != GAP_MAX)    gap_d   = gap_q + 32'd1;
                end
                ST_SEND: begin
                    if (last_hs) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
            if (last_hs) gap_d = '0;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q <= ST_IDLE;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end

`ifdef INTER_PACKET_DELAY_STATS_EN
    logic [31:0] pkt_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            pkt_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else if (sw_rst) begin
            pkt_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (last_hs) pkt_cnt_q <= pkt_cnt_q + 32'd1;
            if ((state_q == ST_IDLE) && s_axis_tvalid && !pass)
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign pkt_cnt   = pkt_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/inter_packet_delay.md
INTER_PACKET_DELAY -- requirements
Module: inter_packet_delay

Interface
REQ-001 SHALL have parameter C_M_AXIS_DATA_WIDTH, default 256, master stream data width.
REQ-002 SHALL have parameter C_S_AXIS_DATA_WIDTH, default 256, slave stream data width (equal to master).
REQ-003 SHALL have parameter C_M_AXIS_TUSER_WIDTH, default 128, master tuser width.
REQ-004 SHALL have parameter C_S_AXIS_TUSER_WIDTH, default 128, slave tuser width.
REQ-005 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, config word width.
REQ-006 SHALL have one clock and an asynchronous active-low reset, as the port list below gives.
- axi_aclk  in  1  sole clock, rising edge.
- axi_aresetn  in  1  asynchronous active-low reset.
- s_axis_tdata/tstrb/tuser/tvalid/tlast  in  256/32/128/1/1  upstream packet stream.
- s_axis_tready  out  1  upstream backpressure.
- m_axis_tdata/tstrb/tuser/tvalid/tlast  out  256/32/128/1/1  stream to the rate limiter.
- m_axis_tready  in  1  downstream backpressure.
- sw_rst  in  1  synchronous soft reset from register block.
- ipd_en  in  1  delay enforcement enable.
- use_reg_delay  in  1  1: delay from delay_reg; 0: delay from s_axis_tuser[63:32].
- delay_reg  in  32  register-supplied inter-packet gap, in clock cycles.

Function
REQ-007 SHALL pass tdata, tstrb, tuser and tlast combinationally, zero latency; m_axis_tvalid = s_axis_tvalid & pass; s_axis_tready = m_axis_tready & pass.
REQ-008 SHALL implement FSM states IDLE (between packets) and SEND (mid-packet).
REQ-009 SHALL keep a 32-bit gap counter: cleared on every tlast handshake, incremented once per cycle in IDLE, saturating at 0xFFFFFFFF, held in SEND.
REQ-010 SHALL select D = delay_reg when use_reg_delay=1, else s_axis_tuser[63:32] of the current first beat.
REQ-011 In IDLE, pass SHALL be 1 iff ipd_en=0 or gap_cnt >= D; D=0 therefore never stalls.
REQ-012 IDLE->SEND SHALL occur on a first-beat handshake with tlast=0; a single-beat packet (tlast=1) SHALL stay in IDLE and clear the gap counter.
REQ-013 In SEND, pass SHALL be 1; SEND->IDLE SHALL occur on the tlast handshake.
REQ-014 Changes to ipd_en, use_reg_delay or delay_reg SHALL affect only the comparison in IDLE, never a packet already in SEND.
REQ-015 With m_axis_tready=0 and the gap satisfied, SHALL hold m_axis_tvalid high without consuming input, keeping the AXIS valid-hold rule.

Reset
REQ-016 axi_aresetn low SHALL asynchronously force IDLE and gap_cnt=0; outputs then are s_axis_tready=0 and m_axis_tvalid=0 unless ipd_en=0.
REQ-017 sw_rst=1 SHALL force IDLE and gap_cnt=0 on the next edge, including mid-packet; the remainder of the interrupted packet is then treated as a new first beat.

Configuration
REQ-018 Macro INTER_PACKET_DELAY_STATS_EN defined SHALL add outputs pkt_cnt[31:0] (tlast handshakes) and stall_cnt[31:0] (IDLE cycles with s_axis_tvalid=1 and pass=0), both wrapping, cleared by either reset.
REQ-019 Without INTER_PACKET_DELAY_STATS_EN, those ports and counters SHALL be absent and the datapath SHALL be unchanged.

Structure
REQ-020 FSM state encodings and the tuser delay-field bit positions (63:32) SHALL reside in the shared OSNT generator package.
REQ-021 SHALL be a single module with no sub-module; the gap counter is inline.

Verification
REQ-022 ipd_en=1, use_reg_delay=1, delay_reg=10, two back-to-back 3-beat packets -> packet 2 first beat leaves exactly 10 cycles after packet 1 tlast handshake.
REQ-023 use_reg_delay=0, tuser[63:32]=0 on every packet, ipd_en=1 -> no stall cycles; throughput equals input.
REQ-024 delay_reg=5, m_axis_tready low for 8 cycles after the gap elapses -> tvalid held 8 cycles, data stable, first beat accepted on tready rise.
REQ-025 sw_rst pulsed on beat 2 of a 4-beat packet with delay_reg=4 -> tready drops; beat 3 emitted 4 cycles later.
REQ-026 Single-beat packets with delay_reg=3 -> one packet per 4 cycles; with STATS_EN, pkt_cnt increments by 1 per packet and stall_cnt by 3 per packet.
